// File: rtl/clk_ctrl_pkg.sv
// Shared definitions for the CPU clock-enable controller: FSM state encoding,
// rate-select width and the rate-select clamping helper.
package clk_ctrl_pkg;

    localparam int unsigned CC_SEL_W = 3;

    typedef enum logic [1:0] {
        CC_STOP   = 2'b00,
        CC_RUN    = 2'b01,
        CC_STEP   = 2'b10,
        CC_HALTED = 2'b11
    } cc_state_e;

    // Maps a non-zero rate select onto a tick index, clamping selects beyond the chain.
    function automatic int unsigned rate_index(input logic [CC_SEL_W-1:0] sel,
                                               input int unsigned         ndec);
        int unsigned s;
        s = {{(32-CC_SEL_W){1'b0}}, sel};
        if (s > ndec) s = ndec;
        return s - 1;
    endfunction

endpackage

// File: rtl/clk_ctrl_btn_deb.sv
// Button conditioner: two-flop synchronizer, stability debounce and a
// registered one-cycle pulse on the debounced rising edge.
module btn_deb #(
    parameter int unsigned DEB_W = 20
) (
    input  logic clk,
    input  logic rst,
    input  logic btn,
    output logic db,
    output logic pulse
);

    logic [1:0]       sync_q,   sync_d;
    logic             stable_q, stable_d;
    logic [DEB_W-1:0] cnt_q,    cnt_d;
    logic             pulse_q,  pulse_d;

    // The count only advances while the synchronized value disagrees with the
    // debounced one; any agreement restarts it from zero.
    always_comb begin
        sync_d   = {sync_q[0], btn};
        stable_d = stable_q;
        cnt_d    = '0;
        pulse_d  = 1'b0;
        if (sync_q[1] != stable_q) begin
            if (cnt_q == '1) begin
                stable_d = sync_q[1];
                pulse_d  = sync_q[1];
            end else begin
                cnt_d = cnt_q + DEB_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync_q   <= '0;
            stable_q <= 1'b0;
            cnt_q    <= '0;
            pulse_q  <= 1'b0;
        end else begin
            sync_q   <= sync_d;
            stable_q <= stable_d;
            cnt_q    <= cnt_d;
            pulse_q  <= pulse_d;
        end
    end

    assign db    = stable_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/clk_ctrl.sv
// CPU clock-enable controller: decade prescaler, rate select and a
// run/stop/step/halt FSM producing a registered one-cycle ce pulse.
module clk_ctrl
    import clk_ctrl_pkg::*;
#(
    parameter int unsigned NDEC  = 8,
    parameter int unsigned DEB_W = 20,
    parameter int unsigned CW    = 32
) (
    input  logic                CLK,
    input  logic                RESET,
    input  logic [CC_SEL_W-1:0] sel,
    input  logic                run_req,
    input  logic                step_btn,
    input  logic                halt,
    output logic                ce,
    output logic [1:0]          state,
    output logic                running,
    output logic [NDEC-1:0]     tick,
    output logic [CW-1:0]       ce_cnt
);

    logic [NDEC-1:0] all9;
    logic            r;
    logic            step_p;
    logic            step_db;

    cc_state_e       state_q,  state_d;
    logic            ce_q,     ce_d;
    logic [CW-1:0]   ce_cnt_q, ce_cnt_d;

    for (genvar i = 0; i < NDEC; i++) begin : g_dec
        logic [3:0] digit_q, digit_d;
        logic       carry_in;

        if (i == 0) begin : g_first
            assign carry_in = 1'b1;
        end else begin : g_rest
            assign carry_in = all9[i-1];
        end

        assign all9[i] = carry_in && (digit_q == 4'd9);

        always_comb begin
            digit_d = digit_q;
            if (carry_in) digit_d = (digit_q == 4'd9) ? 4'd0 : digit_q + 4'd1;
        end

        always_ff @(posedge CLK) begin
            if (RESET) digit_q <= '0;
            else       digit_q <= digit_d;
        end
    end

    assign tick = all9;

    always_comb begin
        int unsigned idx;
        idx = rate_index(sel, NDEC);
        r   = 1'b0;
        if (sel == '0) begin
            r = 1'b1;
        end else begin
            for (int unsigned k = 0; k < NDEC; k++)
                if (k == idx) r = all9[k];
        end
    end

    btn_deb #(.DEB_W(DEB_W)) u_step_deb (
        .clk   (CLK),
        .rst   (RESET),
        .btn   (step_btn),
        .db    (step_db),
        .pulse (step_p)
    );

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            CC_STOP:   if (run_req && !halt) state_d = CC_RUN;
                       else if (step_p)      state_d = CC_STEP;
            CC_RUN:    if (!run_req)         state_d = CC_STOP;
                       else if (halt)        state_d = CC_HALTED;
            CC_STEP:                         state_d = CC_STOP;
            CC_HALTED: if (!run_req)         state_d = CC_STOP;
                       else if (step_p)      state_d = CC_STEP;
            default:                         state_d = CC_STOP;
        endcase
        ce_d     = ((state_q == CC_RUN) && run_req && !halt && r) || (state_q == CC_STEP);
        ce_cnt_d = ce_q ? ce_cnt_q + CW'(1) : ce_cnt_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q  <= CC_STOP;
            ce_q     <= 1'b0;
            ce_cnt_q <= '0;
        end else begin
            state_q  <= state_d;
            ce_q     <= ce_d;
            ce_cnt_q <= ce_cnt_d;
        end
    end

    assign ce      = ce_q;
    assign state   = state_q;
    assign running = (state_q == CC_RUN);
    assign ce_cnt  = ce_cnt_q;

endmodule

// File: tb/tb_clk_ctrl.sv
// Randomized scoreboard bench for clk_ctrl against a cycle-count based
// reference model, plus directed checks of the key scenarios.
module tb_clk_ctrl;

    localparam int unsigned NDEC  = 3;
    localparam int unsigned DEB_W = 4;
    localparam int unsigned CW    = 4;
    localparam int          DEBN  = 1 << DEB_W;

    logic            CLK = 1'b0;
    logic            RESET = 1'b1;
    logic [2:0]      sel = '0;
    logic            run_req = 1'b0;
    logic            step_btn = 1'b0;
    logic            halt = 1'b0;
    logic            ce;
    logic [1:0]      state;
    logic            running;
    logic [NDEC-1:0] tick;
    logic [CW-1:0]   ce_cnt;

    clk_ctrl #(.NDEC(NDEC), .DEB_W(DEB_W), .CW(CW)) dut (
        .CLK      (CLK),
        .RESET    (RESET),
        .sel      (sel),
        .run_req  (run_req),
        .step_btn (step_btn),
        .halt     (halt),
        .ce       (ce),
        .state    (state),
        .running  (running),
        .tick     (tick),
        .ce_cnt   (ce_cnt)
    );

    always #5 CLK = ~CLK;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference model: the prescaler is just the number of edges since reset.
    typedef struct {
        int st;
        int ce;
        int cnt;
        int tk;
    } exp_t;

    exp_t   exp_q[$];
    bit     started = 0;
    longint m_n = 0;
    int     m_st = 0, m_cnt = 0;
    bit     m_ce = 0, m_stable = 0, m_pulse = 0;
    bit     btn_hist[$];
    bit     syn_hist[$];

    function automatic bit hits(longint n, int k);
        longint p = 1;
        for (int i = 0; i < k; i++) p *= 10;
        return (n % p) == p - 1;
    endfunction

    function automatic int tick_of(longint n);
        int t = 0;
        for (int k = 0; k < NDEC; k++)
            if (hits(n, k + 1)) t |= (1 << k);
        return t;
    endfunction

    always @(posedge CLK) begin
        bit r, nce, syn, all_diff;
        int nst, ncnt, k;
        if (RESET) begin
            started  = 1;
            m_n      = 0;
            m_st     = 0;
            m_ce     = 0;
            m_cnt    = 0;
            m_stable = 0;
            m_pulse  = 0;
            btn_hist.delete();
            syn_hist.delete();
        end else if (started) begin
            k    = (int'(sel) > NDEC) ? NDEC : int'(sel);
            r    = (sel == 0) ? 1'b1 : hits(m_n, k);
            nce  = (m_st == 1 && run_req && !halt && r) || m_st == 2;
            ncnt = m_ce ? (m_cnt + 1) % (1 << CW) : m_cnt;
            nst  = m_st;
            case (m_st)
                0: if (run_req && !halt) nst = 1; else if (m_pulse) nst = 2;
                1: if (!run_req) nst = 0; else if (halt) nst = 3;
                2: nst = 0;
                default: if (!run_req) nst = 0; else if (m_pulse) nst = 2;
            endcase
            syn = (btn_hist.size() >= 2) ? btn_hist[btn_hist.size() - 2] : 1'b0;
            btn_hist.push_back(step_btn);
            if (btn_hist.size() > 3) void'(btn_hist.pop_front());
            syn_hist.push_back(syn);
            if (syn_hist.size() > DEBN) void'(syn_hist.pop_front());
            m_pulse = 0;
            if (syn_hist.size() == DEBN) begin
                all_diff = 1;
                foreach (syn_hist[i]) if (syn_hist[i] == m_stable) all_diff = 0;
                if (all_diff) begin
                    m_stable = !m_stable;
                    m_pulse  = m_stable;
                end
            end
            m_st  = nst;
            m_ce  = nce;
            m_cnt = ncnt;
            m_n++;
        end
        if (started) exp_q.push_back('{m_st, int'(m_ce), m_cnt, tick_of(m_n)});
    end

    always @(negedge CLK) begin
        exp_t e;
        if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            check("state",   state,   e.st);
            check("running", running, (e.st == 1) ? 1 : 0);
            check("ce",      ce,      e.ce);
            check("ce_cnt",  ce_cnt,  e.cnt);
            check("tick",    tick,    e.tk);
        end
    end

    task automatic cycles(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    task automatic count_pulses(input string name, input int n, input int gap, output int cnt);
        int last = -1;
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            if (ce) begin
                cnt++;
                if (gap > 0 && last >= 0) check(name, i - last, gap);
                last = i;
            end
        end
        @(posedge CLK);
        #1;
    endtask

    task automatic reset_dut();
        RESET    = 1'b1;
        sel      = 3'($urandom_range(0, 7));
        run_req  = 1'($urandom);
        halt     = 1'($urandom);
        step_btn = 1'($urandom);
        cycles(2);
        RESET    = 1'b0;
        run_req  = 1'b0;
        halt     = 1'b0;
        step_btn = 1'b0;
    endtask

    initial begin
        int cnt;
        bit seen;

        // Idle after reset
        reset_dut();
        cycles(1000);

        // Free-running ce at sel=0
        sel = 0;
        run_req = 1;
        cycles(101);
        run_req = 0;
        cycles(10);

        // Divided rates, including a clamped select
        reset_dut();
        sel = 2;
        run_req = 1;
        cycles(5);
        count_pulses("ce_gap_sel2", 1000, 100, cnt);
        check("ce_count_sel2", cnt, 10);
        sel = 1;
        cycles(20);
        count_pulses("ce_gap_sel1", 200, 10, cnt);
        check("ce_count_sel1", cnt, 20);
        sel = 7;
        cycles(1000);
        count_pulses("ce_gap_sel7", 1000, 0, cnt);
        check("ce_count_sel7", cnt, 1);

        // Single step from STOP
        run_req = 0;
        sel = 0;
        cycles(40);
        step_btn = 1;
        cycles(5);
        step_btn = 0;
        count_pulses("glitch", 40, 0, cnt);
        check("ce_count_glitch", cnt, 0);
        step_btn = 1;
        count_pulses("press", 40, 0, cnt);
        check("ce_count_step", cnt, 1);
        step_btn = 0;
        cycles(40);
        step_btn = 1;
        seen = 0;
        for (int i = 0; i < 60 && !seen; i++) begin
            cycles(1);
            seen = m_pulse;
        end
        check("step_pulse_seen", seen, 1);
        run_req = 1;
        cycles(1);
        check("run_beats_step", state, 1);

        // Halt, step past it, leave HALTED via run_req
        step_btn = 0;
        cycles(40);
        halt = 1;
        cycles(3);
        check("halted_state", state, 3);
        count_pulses("halted", 20, 0, cnt);
        check("ce_count_halted", cnt, 0);
        step_btn = 1;
        halt = 0;
        cycles(40);
        check("step_then_run", state, 1);
        step_btn = 0;
        halt = 1;
        cycles(3);
        run_req = 0;
        cycles(2);
        check("halt_to_stop", state, 0);
        halt = 0;
        run_req = 1;
        cycles(2);
        check("stop_to_run", state, 1);

        // ce_cnt wrap and reset mid-run
        reset_dut();
        sel = 0;
        run_req = 1;
        seen = 0;
        for (int i = 0; i < 100 && !seen; i++) begin
            cycles(1);
            seen = (ce_cnt == 15);
        end
        check("cnt_reached_15", seen, 1);
        cycles(1);
        check("cnt_wrap", ce_cnt, 0);
        cycles(7);
        RESET = 1;
        cycles(1);
        RESET = 0;
        cycles(30);

        // Random traffic
        for (int i = 0; i < 4000; i++) begin
            if ($urandom_range(0, 49) == 0)   sel      = 3'($urandom_range(0, 7));
            if ($urandom_range(0, 79) == 0)   run_req  = !run_req;
            if ($urandom_range(0, 59) == 0)   halt     = !halt;
            if ($urandom_range(0, 19) == 0)   step_btn = !step_btn;
            RESET = ($urandom_range(0, 1499) == 0);
            cycles(1);
        end
        RESET = 0;
        cycles(3);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
